alu_frame_deserializer: RTL
===========================

// Module: alu_frame_deserializer
// PURPOSE
//  DUT-side receiver for the ALU serial input line: samples sin one bit per clk and
//  splits it into 11-bit packets. Assembles 8 data packets plus 1 command packet
//  into operands B, A, the opcode and CRC. Checks the frame and presents one
//  registered result per frame to the ALU core. The block is the far end of the
//  99-bit frame that the testbench BFM drives.
// PARAMETERS
//  DATA_PKTS   8   data packets per frame (4 for B, then 4 for A), MSB byte first
//  PKT_BITS    11  sampled bits per packet: start, type, 8 payload bits, stop
// PORTS
//  clk          in   1   system clock; sin is sampled on the posedge
//  rst          in   1   synchronous reset, active high
//  sin          in   1   serial input; idles at 1
//  frame_valid  out  1   one-cycle pulse: a frame or an error report is complete
//  b            out  32  operand B (data packets 1..4)
//  a            out  32  operand A (data packets 5..8)
//  op           out  3   opcode from the command packet
//  crc          out  4   CRC field from the command packet
//  err_data     out  1   framing or packet-count error (qualified by frame_valid)
//  err_crc      out  1   CRC mismatch (qualified by frame_valid)
//  err_op       out  1   opcode not one of AND/OR/ADD/SUB (qualified by frame_valid)
// BEHAVIOUR
//  - Reset: every output is 0. The FSM goes to IDLE, the packet count is 0 and the
//    shift registers are cleared. A reset mid-frame discards the partial frame with
//    no frame_valid pulse.
//  - Packet layout (sample order): bit0 start=0, bit1 type (0 = data, 1 = cmd),
//    bits2-9 payload MSB first, bit10 stop=1.
//    Command payload = {1'b0, op[2:0], crc[3:0]}.
//  - Packet FSM: IDLE -> DATA -> STOP -> IDLE.
//    - IDLE: stay while sin = 1. sin = 0 is the start bit: go to DATA.
//    - DATA: 9 cycles capture type plus 8 payload bits into a shift register.
//    - STOP: sample the stop bit, return to IDLE. Back-to-back packets are legal:
//      the next start bit may arrive in the cycle after the stop bit.
//  - Data packet with good stop bit, count < 8:
//    b/a byte[7 - count] <= payload, then count++.
//  - Data packet with good stop bit, count = 8: set an overflow flag.
//    Reported at the command packet.
//  - Command packet with good stop bit ends the frame:
//    - err_data = (count != 8) | overflow.
//    - err_crc = !err_data & (crc != crc4({b, a, 1'b1, op})).
//    - err_op = !err_data & !err_crc & (op not in {000, 001, 100, 101}).
//    - Priority is err_data > err_crc > err_op; exactly one error bit is set at most.
//    - Then clear count and overflow.
//  - Stop bit = 0 on any packet: pulse frame_valid with err_data = 1 only.
//    Clear count and overflow, return to IDLE.
//  - Latency: frame_valid, b, a, op, crc and the error flags are registered on the
//    same posedge that samples the final stop bit. They are visible in the
//    following cycle.
//  - Output hold: b, a, op, crc and the error flags hold until the next frame_valid.
//    frame_valid is high for one cycle only.
//  - CRC: CRC-4, polynomial x^4+x+1, initial value 0, MSB first over 68 bits.
// CONFIGURATION
//  - ALU_DESER_CRC_CHECK_EN defined: CRC is checked as described above.
//  - ALU_DESER_CRC_CHECK_EN undefined: the CRC checker is omitted and err_crc is
//    tied to 0. err_op is still evaluated when err_data = 0. The crc output is
//    still driven.
// STRUCTURE
//  - alu_pkg (shared) holds:
//    - operation_t opcode values (AND 000, OR 001, ADD 100, SUB 101)
//    - PKT_DATA / PKT_CMD type-bit constants
//    - function crc4(bit [67:0]), shared with the BFM and scoreboard
//  - Sub-module alu_packet_rx: bit-level packet FSM.
//    - Inputs: clk, rst, sin.
//    - Outputs: pkt_valid, pkt_type, pkt_payload[7:0], pkt_stop_err.
//  - Top level: packet count, byte placement, checks and output registers.
// TESTING
//  1. B=32'h0000_0003, A=32'h0000_0005, op=100, crc=crc4() ->
//     one frame_valid, b=3, a=5, op=100, all error flags 0.
//  2. Same frame with crc xor 4'h1 -> frame_valid with err_crc=1,
//     err_data=0, err_op=0.
//  3. 7 data packets then a valid command -> frame_valid with err_data=1 only.
//     The next good frame decodes cleanly.
//  4. Valid CRC with op=3'b111 -> frame_valid with err_op=1 only.
//  5. Stop bit forced to 0 in data packet 3 -> frame_valid with err_data=1
//     on that stop bit. The remaining packets and the command then report
//     err_data (count = 5).
//  6. rst pulsed after 50 bits of a frame, then a full frame 32'hDEAD_BEEF /
//     32'h1234_5678 with op=000 -> exactly one frame_valid with
//     b=32'hDEAD_BEEF, a=32'h1234_5678, no error flags.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU serial-frame receiver, its BFM and its
// scoreboard: opcode encodings, packet type-bit values, frame geometry,
// receiver FSM states and the CRC-4 used to protect each frame.
// Ports: none (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_PKTS = 8;   // 4 bytes of B, then 4 bytes of A
    localparam int PKT_BITS  = 11;  // start, type, 8 payload bits, stop

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic PKT_DATA = 1'b0;
    localparam logic PKT_CMD  = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // CRC-4, polynomial x^4+x+1, initial value 0, MSB first.
    function automatic bit [3:0] crc4(input bit [67:0] data);
        bit [3:0] c;
        bit       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ data[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_packet_rx.sv
// ---------------------------------------------------------------------------
// alu_packet_rx
// Bit-level receiver for one 11-bit packet on the serial line.
// IDLE waits for a 0 start bit, DATA shifts in the type bit plus 8 payload
// bits (MSB first), STOP samples the stop bit and returns to IDLE, so the
// next start bit may follow in the very next cycle.
// Ports:
//   clk           in   system clock, sin sampled on posedge
//   rst           in   synchronous reset, active high
//   sin           in   serial input, idles at 1
//   pkt_valid     out  high during the stop-bit cycle of a packet
//   pkt_type      out  0 = data packet, 1 = command packet
//   pkt_payload   out  8-bit payload of the packet
//   pkt_stop_err  out  stop bit currently on sin is 0 (qualified by pkt_valid)
// The packet flags are decoded from the registered state so that the top
// level can register its results on the same edge that samples the stop bit.
// ---------------------------------------------------------------------------
module alu_packet_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic       pkt_valid,
    output logic       pkt_type,
    output logic [7:0] pkt_payload,
    output logic       pkt_stop_err
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(PKT_BITS - 3);

    rx_state_t  state;
    logic [3:0] bit_cnt;
    logic [8:0] shift;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!sin) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    shift <= {shift[7:0], sin};
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state <= RX_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                RX_STOP: begin
                    state <= RX_IDLE;
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    assign pkt_valid    = (state == RX_STOP);
    assign pkt_type     = shift[8];
    assign pkt_payload  = shift[7:0];
    assign pkt_stop_err = pkt_valid & ~sin;

endmodule

// File: rtl/alu_frame_deserializer.sv
// ---------------------------------------------------------------------------
// alu_frame_deserializer
// Assembles 8 data packets and 1 command packet from the serial line into
// operands B and A, opcode and CRC, checks the frame and presents one
// registered result per frame.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active high
//   sin          in   serial input, idles at 1
//   frame_valid  out  one-cycle pulse: frame or error report complete
//   b            out  operand B (data packets 1..4)
//   a            out  operand A (data packets 5..8)
//   op           out  opcode from the command packet
//   crc          out  CRC field from the command packet
//   err_data     out  framing / packet-count error
//   err_crc      out  CRC mismatch
//   err_op       out  unsupported opcode
// Configuration macro: ALU_DESER_CRC_CHECK_EN enables the CRC check; when
// undefined, err_crc is tied to 0 and crc is still reported.
// ---------------------------------------------------------------------------
module alu_frame_deserializer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        frame_valid,
    output logic [31:0] b,
    output logic [31:0] a,
    output logic [2:0]  op,
    output logic [3:0]  crc,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    localparam logic [3:0] FULL_COUNT = 4'(DATA_PKTS);

    logic       pkt_valid;
    logic       pkt_type;
    logic [7:0] pkt_payload;
    logic       pkt_stop_err;

    alu_packet_rx u_packet_rx (
        .clk          (clk),
        .rst          (rst),
        .sin          (sin),
        .pkt_valid    (pkt_valid),
        .pkt_type     (pkt_type),
        .pkt_payload  (pkt_payload),
        .pkt_stop_err (pkt_stop_err)
    );

    logic [3:0]  count;
    logic        overflow;
    logic [63:0] ba;        // {B, A} under assembly, byte 7 = B MSB
    logic [2:0]  byte_idx;

    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc;
    logic        crc_bad;
    logic        cmd_err_data;
    logic        cmd_err_crc;
    logic        cmd_err_op;

    assign byte_idx = 3'(DATA_PKTS - 1) - count[2:0];
    assign cmd_op   = pkt_payload[6:4];
    assign cmd_crc  = pkt_payload[3:0];

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        crc_bad = 1'b0;
`ifdef ALU_DESER_CRC_CHECK_EN
        crc_bad = (cmd_crc != crc4({ba, 1'b1, cmd_op}));
`endif
        cmd_err_data = (count != FULL_COUNT) | overflow;
        cmd_err_crc  = ~cmd_err_data & crc_bad;
        cmd_err_op   = ~cmd_err_data & ~cmd_err_crc & ~op_is_valid(cmd_op);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            overflow    <= 1'b0;
            ba          <= '0;
            frame_valid <= 1'b0;
            b           <= '0;
            a           <= '0;
            op          <= '0;
            crc         <= '0;
            err_data    <= 1'b0;
            err_crc     <= 1'b0;
            err_op      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (pkt_valid) begin
                if (pkt_stop_err) begin
                    // Broken packet: report immediately, restart the frame.
                    frame_valid <= 1'b1;
                    err_data    <= 1'b1;
                    err_crc     <= 1'b0;
                    err_op      <= 1'b0;
                    count       <= '0;
                    overflow    <= 1'b0;
                end else if (pkt_type == PKT_DATA) begin
                    if (count < FULL_COUNT) begin
                        ba[{byte_idx, 3'b000} +: 8] <= pkt_payload;
                        count <= count + 4'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    frame_valid <= 1'b1;
                    b           <= ba[63:32];
                    a           <= ba[31:0];
                    op          <= cmd_op;
                    crc         <= cmd_crc;
                    err_data    <= cmd_err_data;
                    err_crc     <= cmd_err_crc;
                    err_op      <= cmd_err_op;
                    count       <= '0;
                    overflow    <= 1'b0;
                end
            end
        end
    end

endmodule
